// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS datapath.
// Each instruction is sequenced through FETCH/DECODE/EXE/MEM/WB, and the
// existing datapath select codes are driven one state at a time. MEM waits on
// the data-memory ready handshake. Illegal opcodes and memory timeouts enter an
// absorbing TRAP state. Retired instructions are counted.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   op, funct           ins[31:26], ins[5:0] of the current instruction
//   Zero, OF            ALU flags (Zero goes to npc; OF gates addi writeback)
//   mem_rdy             dm access completes this cycle
//   pc_wr, ir_wr        PC / IR load enables
//   RegWrite, memwr,
//   mem_rd              GPR write enable, dm write strobe, dm read request
//   ALUSrc, ExtOp,
//   Luisel, slt, addi   datapath selects
//   RegDst, MemtoReg,
//   ALUctr, N_pcsel     2-bit datapath select codes
//   trap, trap_code     sticky error flag and cause (01 illegal, 10 timeout)
//   instret             retired-instruction count
module mc_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        Zero,
  input  logic        OF,
  input  logic        mem_rdy,
  output logic        pc_wr,
  output logic        ir_wr,
  output logic        RegWrite,
  output logic        memwr,
  output logic        mem_rd,
  output logic        ALUSrc,
  output logic        ExtOp,
  output logic        Luisel,
  output logic        slt,
  output logic        addi,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUctr,
  output logic [1:0]  N_pcsel,
  output logic        trap,
  output logic [1:0]  trap_code,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_LW, I_SW, I_BEQ,
    I_LUI, I_J, I_JAL, I_ADDI, I_ILL
  } instr_t;

  // The 15th consecutive not-ready cycle in MEM is the one that traps.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  instr_t     ins;

  // Zero steers the npc branch mux directly; the FSM itself does not need it.
  logic unused_zero;
  assign unused_zero = Zero;

  function automatic instr_t classify(input logic [5:0] o, input logic [5:0] f);
    instr_t k;
    k = I_ILL;
    case (o)
      6'b000000: begin
        case (f)
          6'b100001: k = I_ADDU;
          6'b100011: k = I_SUBU;
          6'b101010: k = I_SLT;
          6'b001000: k = I_JR;
          default:   k = I_ILL;
        endcase
      end
      6'b001101: k = I_ORI;
      6'b100011: k = I_LW;
      6'b101011: k = I_SW;
      6'b000100: k = I_BEQ;
      6'b001111: k = I_LUI;
      6'b000010: k = I_J;
      6'b000011: k = I_JAL;
      6'b001000: k = I_ADDI;
      default:   k = I_ILL;
    endcase
    return k;
  endfunction

  assign ins = classify(op, funct);

  always_comb begin
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    RegWrite = 1'b0;
    memwr    = 1'b0;
    mem_rd   = 1'b0;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    Luisel   = 1'b0;
    slt      = 1'b0;
    addi     = 1'b0;
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    ALUctr   = 2'b00;
    N_pcsel  = 2'b00;

    // ALU selects are held across EXE, MEM and WB of the same instruction.
    if (state == S_EXE || state == S_MEM || state == S_WB) begin
      case (ins)
        I_SUBU, I_BEQ: ALUctr = 2'b01;
        I_SLT:         begin ALUctr = 2'b01; slt = 1'b1; end
        I_ORI:         begin ALUSrc = 1'b1; ALUctr = 2'b10; end
        I_LUI:         begin ALUSrc = 1'b1; Luisel = 1'b1; ALUctr = 2'b10; end
        I_ADDI:        begin ALUSrc = 1'b1; ExtOp = 1'b1; addi = 1'b1; end
        I_LW, I_SW:    begin ALUSrc = 1'b1; ExtOp = 1'b1; end
        default:       ;
      endcase
    end

    case (state)
      S_FETCH: ir_wr = 1'b1;
      S_DECODE: begin
        case (ins)
          I_J:   begin pc_wr = 1'b1; N_pcsel = 2'b10; end
          I_JR:  begin pc_wr = 1'b1; N_pcsel = 2'b11; end
          I_JAL: begin
            RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10;
            pc_wr = 1'b1; N_pcsel = 2'b10;
          end
          default: ;
        endcase
      end
      S_EXE: begin
        if (ins == I_BEQ) begin
          pc_wr   = 1'b1;
          N_pcsel = 2'b01;
        end
      end
      S_MEM: begin
        mem_rd = (ins == I_LW);
        memwr  = (ins == I_SW);
        if (ins == I_SW && mem_rdy) pc_wr = 1'b1;
      end
      S_WB: begin
        pc_wr    = 1'b1;
        RegWrite = !(ins == I_ADDI && OF);
        if (ins == I_ADDU || ins == I_SUBU || ins == I_SLT) RegDst = 2'b01;
        if (ins == I_LW) MemtoReg = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= 4'd0;
      instret   <= 32'd0;
      trap      <= 1'b0;
      trap_code <= 2'b00;
    end else begin
      if (pc_wr) instret <= instret + 32'd1;
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (ins == I_ILL) begin
            state     <= S_TRAP;
            trap      <= 1'b1;
            trap_code <= 2'b01;
          end else if (ins == I_J || ins == I_JR || ins == I_JAL) begin
            state <= S_FETCH;
          end else begin
            state <= S_EXE;
          end
        end
        S_EXE: begin
          if (ins == I_BEQ)                    state <= S_FETCH;
          else if (ins == I_LW || ins == I_SW) state <= S_MEM;
          else                                 state <= S_WB;
        end
        S_MEM: begin
          if (mem_rdy) begin
            wait_cnt <= 4'd0;
            state    <= (ins == I_LW) ? S_WB : S_FETCH;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= 4'd0;
            state     <= S_TRAP;
            trap      <= 1'b1;
            trap_code <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
